// File: rtl/modulo_escalonador_buffer_rolhas_if.sv
// Handshake and counter bus between the operator/capping logic and the cork buffer sequencer.
interface modulo_escalonador_buffer_rolhas_if;
   logic       enable;
   logic       op_req;
   logic [6:0] op_qtd;
   logic       sel_ved;
   logic       op_ack;
   logic       op_err;
   logic [6:0] sec_cnt;
   logic [4:0] pri_cnt;
   logic       ro;
   logic       busy;
   logic [1:0] estado;

   // Requester side: drives commands, observes counters and pulses.
   modport master (
      output enable, op_req, op_qtd, sel_ved,
      input  op_ack, op_err, sec_cnt, pri_cnt, ro, busy, estado
   );

   // Sequencer side.
   modport slave (
      input  enable, op_req, op_qtd, sel_ved,
      output op_ack, op_err, sec_cnt, pri_cnt, ro, busy, estado
   );
endinterface

// File: rtl/modulo_escalonador_buffer_rolhas.sv
// Round-robin arbiter/sequencer for the secondary and main cork buffers.
// Moves one cork per clock for operator loads (into secondary) and refill
// transfers (secondary -> main), and tracks main-buffer consumption.
module modulo_escalonador_buffer_rolhas #(
   parameter int unsigned SEC_MAX = 99,
   parameter int unsigned PRI_MAX = 20,
   parameter int unsigned PRI_MIN = 5,
   parameter int unsigned LOTE    = 15
) (
   input logic clk,
   input logic rst,
   modulo_escalonador_buffer_rolhas_if.slave bus
);

   localparam int unsigned SEC_W = 7;
   localparam int unsigned PRI_W = 5;
   localparam int unsigned REM_W = 7;
   localparam int unsigned SUM_W = 8;

   localparam logic [SEC_W-1:0] SEC_MAX_V = SEC_W'(SEC_MAX);
   localparam logic [PRI_W-1:0] PRI_MAX_V = PRI_W'(PRI_MAX);
   localparam logic [PRI_W-1:0] PRI_MIN_V = PRI_W'(PRI_MIN);
   localparam logic [SEC_W-1:0] LOTE_SEC  = SEC_W'(LOTE);
   localparam logic [REM_W-1:0] LOTE_REM  = REM_W'(LOTE);
   localparam logic [SUM_W-1:0] SEC_MAX_S = SUM_W'(SEC_MAX);

   typedef enum logic [1:0] {
      OCIOSO = 2'b00,
      CARGA  = 2'b01,
      TRANSF = 2'b10,
      INVAL  = 2'b11
   } estado_t;

   estado_t          r_estado,     w_estado_nxt;
   logic [SEC_W-1:0] r_sec_cnt,    w_sec_cnt_nxt;
   logic [PRI_W-1:0] r_pri_cnt,    w_pri_cnt_nxt;
   logic [REM_W-1:0] r_rem,        w_rem_nxt;
   logic             r_op_pend,    w_op_pend_nxt;
   logic [SEC_W-1:0] r_op_qtd,     w_op_qtd_nxt;
   logic             r_last_grant, w_last_grant_nxt;
   logic             r_op_ack,     w_op_ack_nxt;
   logic             r_op_err,     w_op_err_nxt;

   logic             w_tr_req;
   logic             w_grant_op;
   logic             w_grant_tr;
   logic             w_drop;
   logic             w_tr_step;
   logic             w_consume;
   logic [SUM_W-1:0] w_sum;

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_estado     <= OCIOSO;
         r_sec_cnt    <= '0;
         r_pri_cnt    <= '0;
         r_rem        <= '0;
         r_op_pend    <= 1'b0;
         r_op_qtd     <= '0;
         r_last_grant <= 1'b1;
         r_op_ack     <= 1'b0;
         r_op_err     <= 1'b0;
      end else begin
         r_estado     <= w_estado_nxt;
         r_sec_cnt    <= w_sec_cnt_nxt;
         r_pri_cnt    <= w_pri_cnt_nxt;
         r_rem        <= w_rem_nxt;
         r_op_pend    <= w_op_pend_nxt;
         r_op_qtd     <= w_op_qtd_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_op_ack     <= w_op_ack_nxt;
         r_op_err     <= w_op_err_nxt;
      end
   end

   // Next-state: request capture, arbitration, cork stepping, consumption.
   always_comb begin
      w_estado_nxt     = r_estado;
      w_sec_cnt_nxt    = r_sec_cnt;
      w_pri_cnt_nxt    = r_pri_cnt;
      w_rem_nxt        = r_rem;
      w_op_pend_nxt    = r_op_pend;
      w_op_qtd_nxt     = r_op_qtd;
      w_last_grant_nxt = r_last_grant;
      w_op_ack_nxt     = 1'b0;
      w_op_err_nxt     = 1'b0;
      w_drop           = 1'b0;
      w_tr_step        = 1'b0;

      w_tr_req   = bus.enable && (r_pri_cnt <= PRI_MIN_V) && (r_sec_cnt >= LOTE_SEC);
      w_sum      = {1'b0, r_sec_cnt} + {1'b0, r_op_qtd};
      w_grant_op = r_op_pend && (!w_tr_req || r_last_grant);
      w_grant_tr = w_tr_req && (!r_op_pend || !r_last_grant);
      w_consume  = bus.sel_ved && (r_pri_cnt != '0);

      // A request is accepted only when nothing is queued and no load is running.
      if (bus.op_req) begin
         if (!r_op_pend && (r_estado != CARGA)) begin
            w_op_pend_nxt = 1'b1;
            w_op_qtd_nxt  = bus.op_qtd;
         end else begin
            w_drop = 1'b1;
         end
      end

      case (r_estado)
         OCIOSO: begin
            if (bus.enable) begin
               if (w_grant_op) begin
                  w_last_grant_nxt = 1'b0;
                  w_op_pend_nxt    = 1'b0;
                  if ((r_op_qtd == '0) || (w_sum > SEC_MAX_S)) begin
                     w_op_err_nxt = 1'b1;
                  end else begin
                     w_rem_nxt    = r_op_qtd;
                     w_estado_nxt = CARGA;
                  end
               end else if (w_grant_tr) begin
                  w_last_grant_nxt = 1'b1;
                  w_rem_nxt        = LOTE_REM;
                  w_estado_nxt     = TRANSF;
               end
            end
         end
         CARGA: begin
            if (!bus.enable) begin
               w_estado_nxt = OCIOSO;
               w_rem_nxt    = '0;
               w_op_err_nxt = 1'b1;
            end else begin
               if (r_sec_cnt < SEC_MAX_V) w_sec_cnt_nxt = r_sec_cnt + SEC_W'(1);
               if (r_rem != '0)           w_rem_nxt     = r_rem - REM_W'(1);
               if (r_rem <= REM_W'(1)) begin
                  w_estado_nxt = OCIOSO;
                  w_op_ack_nxt = 1'b1;
               end
            end
         end
         TRANSF: begin
            if (!bus.enable) begin
               w_estado_nxt = OCIOSO;
               w_rem_nxt    = '0;
            end else begin
               w_tr_step = 1'b1;
               if (r_sec_cnt != '0) w_sec_cnt_nxt = r_sec_cnt - SEC_W'(1);
               if (r_rem != '0)     w_rem_nxt     = r_rem - REM_W'(1);
               if (r_rem <= REM_W'(1)) w_estado_nxt = OCIOSO;
            end
         end
         default: begin
            w_estado_nxt = OCIOSO;
            w_rem_nxt    = '0;
         end
      endcase

      // A transfer move and a consumption in the same cycle cancel out.
      if (w_tr_step && !w_consume) begin
         if (r_pri_cnt < PRI_MAX_V) w_pri_cnt_nxt = r_pri_cnt + PRI_W'(1);
      end else if (!w_tr_step && w_consume) begin
         w_pri_cnt_nxt = r_pri_cnt - PRI_W'(1);
      end

      // The completion ack wins over a coincident dropped request so the two pulses never overlap.
      if (w_drop && !w_op_ack_nxt) w_op_err_nxt = 1'b1;
   end

   assign bus.op_ack  = r_op_ack;
   assign bus.op_err  = r_op_err;
   assign bus.sec_cnt = r_sec_cnt;
   assign bus.pri_cnt = r_pri_cnt;
   assign bus.ro      = (r_pri_cnt == '0);
   assign bus.busy    = (r_estado != OCIOSO);
   assign bus.estado  = r_estado;

endmodule

// File: tb/tb_modulo_escalonador_buffer_rolhas.sv
// Self-checking bench: vector table, directed corner sequences, randomized run against a reference model.
module tb_modulo_escalonador_buffer_rolhas;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   n_ack    = 0;
   int   n_err    = 0;

   modulo_escalonador_buffer_rolhas_if bus();

   modulo_escalonador_buffer_rolhas dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       en;
      logic       req;
      logic [6:0] qtd;
      logic       sel;
      logic [6:0] e_sec;
      logic [4:0] e_pri;
      logic [1:0] e_est;
      logic       e_ack;
      logic       e_err;
   } vec_t;

   vec_t vecs [16];

   // Reference model state (transaction view: job kind + corks left).
   int m_sec, m_pri, m_left, m_job, m_qtd;
   bit m_pend, m_lg, m_ack, m_err;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.enable = 1'b0; bus.op_req = 1'b0; bus.op_qtd = '0; bus.sel_ved = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   // Tick until idle for 3 consecutive samples, counting pulses seen.
   task automatic wait_idle();
      int idle = 0;
      int n = 0;
      n_ack = 0; n_err = 0;
      while (idle < 3 && n < 300) begin
         tick();
         n++;
         if (bus.op_ack) n_ack++;
         if (bus.op_err) n_err++;
         idle = bus.busy ? 0 : idle + 1;
      end
      chk("wait_idle_in_budget", int'(n < 300), 1);
   endtask

   task automatic model_reset();
      m_sec = 0; m_pri = 0; m_left = 0; m_job = 0; m_qtd = 0;
      m_pend = 0; m_lg = 1; m_ack = 0; m_err = 0;
   endtask

   // One clock edge of the specified behaviour, from the inputs present at that edge.
   task automatic model_edge(input bit en, input bit req, input int qtd, input bit sel);
      bit tr, moved, dropped, consumed, pend;
      int sec, job, left;
      tr = en && (m_pri <= 5) && (m_sec >= 15);
      sec = m_sec; job = m_job; left = m_left; pend = m_pend;
      moved = 0; dropped = 0;
      m_ack = 0; m_err = 0;
      if (req) begin
         if (!m_pend && m_job != 1) begin pend = 1; m_qtd = qtd; end
         else dropped = 1;
      end
      if (m_job == 0) begin
         if (en && m_pend && (!tr || m_lg)) begin
            m_lg = 0; pend = 0;
            if (m_qtd == 0 || m_sec + m_qtd > 99) m_err = 1;
            else begin job = 1; left = m_qtd; end
         end else if (en && tr) begin
            m_lg = 1; job = 2; left = 15;
         end
      end else if (!en) begin
         m_err = (m_job == 1);
         job = 0; left = 0;
      end else if (m_job == 1) begin
         sec++; left--;
         if (left == 0) begin job = 0; m_ack = 1; end
      end else begin
         sec--; moved = 1; left--;
         if (left == 0) job = 0;
      end
      consumed = sel && (m_pri > 0);
      m_pri = m_pri + int'(moved) - int'(consumed);
      if (dropped && !m_ack) m_err = 1;
      m_sec = sec; m_job = job; m_left = left; m_pend = pend;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      // en req qtd sel | sec pri est ack err
      vecs[0]  = '{1'b1, 1'b1, 7'd3,  1'b0, 7'd0, 5'd0, 2'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 7'd0,  1'b0, 7'd0, 5'd0, 2'd1, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 7'd0,  1'b0, 7'd1, 5'd0, 2'd1, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 7'd0,  1'b0, 7'd2, 5'd0, 2'd1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 7'd0,  1'b0, 7'd3, 5'd0, 2'd0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 7'd0,  1'b0, 7'd3, 5'd0, 2'd0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 7'd0,  1'b0, 7'd3, 5'd0, 2'd0, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 7'd97, 1'b0, 7'd3, 5'd0, 2'd0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 7'd0,  1'b0, 7'd3, 5'd0, 2'd0, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 7'd0,  1'b1, 7'd3, 5'd0, 2'd0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 7'd2,  1'b0, 7'd3, 5'd0, 2'd0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 7'd0,  1'b0, 7'd3, 5'd0, 2'd0, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 7'd0,  1'b0, 7'd3, 5'd0, 2'd1, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 7'd5,  1'b0, 7'd4, 5'd0, 2'd1, 1'b0, 1'b1};
      vecs[14] = '{1'b1, 1'b1, 7'd5,  1'b0, 7'd5, 5'd0, 2'd0, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 7'd0,  1'b0, 7'd5, 5'd0, 2'd0, 1'b0, 1'b0};

      rst = 1'b0;
      do_reset();
      chk("reset_sec", bus.sec_cnt, 0);
      chk("reset_ro", bus.ro, 1);
      chk("reset_estado", bus.estado, 0);

      // Reset asserted mid-CARGA clears outputs without waiting for a clock edge.
      bus.enable = 1'b1; bus.op_req = 1'b1; bus.op_qtd = 7'd30;
      tick(); bus.op_req = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("pre_reset_in_carga", bus.estado, 1);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_sec", bus.sec_cnt, 0);
      chk("async_rst_pri", bus.pri_cnt, 0);
      chk("async_rst_estado", bus.estado, 0);
      chk("async_rst_busy", bus.busy, 0);
      chk("async_rst_ro", bus.ro, 1);
      chk("async_rst_pulses", {bus.op_ack, bus.op_err}, 0);
      tick(); rst = 1'b0;
      tick(); tick();
      chk("post_rst_idle", bus.estado, 0);
      chk("post_rst_sec", bus.sec_cnt, 0);

      // Operator load of 30 then automatic refill transfer.
      bus.op_req = 1'b1; bus.op_qtd = 7'd30;
      tick(); bus.op_req = 1'b0;
      tick();
      chk("load30_granted", bus.estado, 1);
      c = 0;
      while (bus.estado == 2'd1 && c < 100) begin tick(); c++; end
      chk("load30_carga_cycles", c, 30);
      chk("load30_sec", bus.sec_cnt, 30);
      chk("load30_ack", bus.op_ack, 1);
      chk("load30_busy_low", bus.busy, 0);
      tick();
      chk("load30_ack_single", bus.op_ack, 0);
      chk("load30_then_transf", bus.estado, 2);
      wait_idle();
      chk("transf_sec", bus.sec_cnt, 15);
      chk("transf_pri", bus.pri_cnt, 15);

      // Capacity limits.
      bus.op_req = 1'b1; bus.op_qtd = 7'd75; tick(); bus.op_req = 1'b0;
      wait_idle();
      chk("cap_sec90", bus.sec_cnt, 90);
      bus.op_req = 1'b1; bus.op_qtd = 7'd10; tick(); bus.op_req = 1'b0; tick();
      chk("cap_reject10_err", bus.op_err, 1);
      chk("cap_reject10_sec", bus.sec_cnt, 90);
      tick();
      chk("cap_err_single", bus.op_err, 0);
      bus.op_req = 1'b1; bus.op_qtd = 7'd9; tick(); bus.op_req = 1'b0;
      wait_idle();
      chk("cap_fill99_sec", bus.sec_cnt, 99);
      chk("cap_fill99_ack", n_ack, 1);
      chk("cap_fill99_noerr", n_err, 0);
      bus.op_req = 1'b1; bus.op_qtd = 7'd0; tick(); bus.op_req = 1'b0; tick();
      chk("cap_zero_err", bus.op_err, 1);
      chk("cap_zero_sec", bus.sec_cnt, 99);

      // Arbitration: both pending with last_grant = transfer -> operator first.
      do_reset();
      bus.enable = 1'b1; bus.op_req = 1'b1; bus.op_qtd = 7'd55; tick(); bus.op_req = 1'b0;
      wait_idle();
      chk("arb_setup_sec", bus.sec_cnt, 40);
      bus.enable = 1'b0; bus.sel_ved = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      bus.sel_ved = 1'b0;
      chk("arb_setup_pri", bus.pri_cnt, 3);
      bus.op_req = 1'b1; bus.op_qtd = 7'd5; tick(); bus.op_req = 1'b0;
      bus.enable = 1'b1; tick();
      chk("arb_carga_first", bus.estado, 1);
      c = 0;
      while (!bus.op_ack && c < 50) begin tick(); c++; end
      chk("arb_ack_seen", bus.op_ack, 1);
      chk("arb_sec45", bus.sec_cnt, 45);
      chk("arb_pri3", bus.pri_cnt, 3);
      wait_idle();
      chk("arb_sec30", bus.sec_cnt, 30);
      chk("arb_pri18", bus.pri_cnt, 18);

      // Consumption coinciding with every transfer move.
      bus.enable = 1'b0; bus.sel_ved = 1'b1;
      for (int i = 0; i < 13; i++) tick();
      bus.sel_ved = 1'b0;
      chk("cons_setup_pri", bus.pri_cnt, 5);
      bus.enable = 1'b1; tick();
      chk("cons_transf", bus.estado, 2);
      c = 0;
      while (bus.estado == 2'd2 && c < 20) begin
         bus.sel_ved = 1'b1; tick(); c++;
         chk("cons_pri_hold", bus.pri_cnt, 5);
      end
      bus.sel_ved = 1'b0; bus.enable = 1'b0;
      chk("cons_moves", c, 15);
      chk("cons_sec", bus.sec_cnt, 15);
      bus.sel_ved = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      bus.sel_ved = 1'b0;
      chk("cons_at_zero_pri", bus.pri_cnt, 0);
      chk("cons_at_zero_ro", bus.ro, 1);

      // Abort of a running load, then a request dropped during CARGA.
      do_reset();
      bus.enable = 1'b1; bus.op_req = 1'b1; bus.op_qtd = 7'd20; tick(); bus.op_req = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) tick();
      bus.enable = 1'b0; tick();
      chk("abort_estado", bus.estado, 0);
      chk("abort_err", bus.op_err, 1);
      chk("abort_ack", bus.op_ack, 0);
      chk("abort_sec", bus.sec_cnt, 4);
      bus.enable = 1'b1;
      bus.op_req = 1'b1; bus.op_qtd = 7'd3; tick(); bus.op_req = 1'b0; tick();
      bus.op_req = 1'b1; bus.op_qtd = 7'd5; tick(); bus.op_req = 1'b0;
      chk("drop_err", bus.op_err, 1);
      chk("drop_still_carga", bus.estado, 1);
      wait_idle();
      chk("drop_ignored_sec", bus.sec_cnt, 7);
      chk("drop_ack", n_ack, 1);

      // Vector table.
      do_reset();
      foreach (vecs[i]) begin
         bus.enable = vecs[i].en; bus.op_req = vecs[i].req;
         bus.op_qtd = vecs[i].qtd; bus.sel_ved = vecs[i].sel;
         tick();
         chk($sformatf("vec%0d_sec", i), bus.sec_cnt, vecs[i].e_sec);
         chk($sformatf("vec%0d_pri", i), bus.pri_cnt, vecs[i].e_pri);
         chk($sformatf("vec%0d_estado", i), bus.estado, vecs[i].e_est);
         chk($sformatf("vec%0d_ack", i), bus.op_ack, vecs[i].e_ack);
         chk($sformatf("vec%0d_err", i), bus.op_err, vecs[i].e_err);
         chk($sformatf("vec%0d_busy", i), bus.busy, int'(vecs[i].e_est != 2'd0));
         chk($sformatf("vec%0d_ro", i), bus.ro, int'(vecs[i].e_pri == 5'd0));
      end

      // Randomized run against the reference model.
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int exp_v, act_v;
         bus.enable  = ($urandom_range(0, 99) < 92);
         bus.op_req  = ($urandom_range(0, 99) < 8);
         bus.op_qtd  = 7'($urandom_range(0, 50));
         bus.sel_ved = ($urandom_range(0, 99) < 25);
         model_edge(bus.enable, bus.op_req, int'(bus.op_qtd), bus.sel_ved);
         tick();
         exp_v = (m_sec << 16) | (m_pri << 8) | (m_job << 4) | (int'(m_ack) << 3)
               | (int'(m_err) << 2) | (int'(m_job != 0) << 1) | int'(m_pri == 0);
         act_v = (int'(bus.sec_cnt) << 16) | (int'(bus.pri_cnt) << 8) | (int'(bus.estado) << 4)
               | (int'(bus.op_ack) << 3) | (int'(bus.op_err) << 2) | (int'(bus.busy) << 1)
               | int'(bus.ro);
         checks++;
         if (act_v != exp_v) begin
            failures++;
            $display("FAIL rand_cyc%0d actual sec=%0d pri=%0d est=%0d ack=%0d err=%0d busy=%0d ro=%0d required sec=%0d pri=%0d est=%0d ack=%0d err=%0d",
                     cyc, bus.sec_cnt, bus.pri_cnt, bus.estado, bus.op_ack, bus.op_err, bus.busy, bus.ro,
                     m_sec, m_pri, m_job, m_ack, m_err);
         end
         if (bus.op_ack && bus.op_err) chk("rand_ack_err_exclusive", 1, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/modulo_escalonador_buffer_rolhas.md
# modulo_escalonador_buffer_rolhas

Arbiter and sequencer for the cork (rolha) buffers of the bottling line. It arbitrates between two requesters of the shared secondary-buffer counter, round-robin:
- operator bulk loads into the secondary buffer;
- automatic refill transfers from the secondary buffer to the main (capping) buffer.

It steps the counters one cork per clock and tracks main-buffer consumption from the capping stage. It sits between the operator debounce/pulse logic and the capping FSM, and owns the `sec_cnt`/`pri_cnt` values that drive the display encoders and the `ro` input of the filling/capping FSM.

## Interface
Parameters:
- SEC_MAX, 99: secondary-buffer capacity.
- PRI_MAX, 20: main-buffer capacity (fits 5 bits).
- PRI_MIN, 5: refill threshold. A transfer is requested when `pri_cnt` <= PRI_MIN.
- LOTE, 15: corks moved per transfer. Legal parameter sets satisfy PRI_MIN + LOTE <= PRI_MAX and LOTE <= SEC_MAX.

Ports:
- clk  in  1  single system clock (divided clock domain); all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  machine running (start_stop). Low: no new grants, and any running operation is aborted.
- op_req  in  1  one-cycle pulse: operator load request.
- op_qtd  in  7  corks to add; sampled together with op_req.
- sel_ved  in  1  one-cycle pulse: one cork consumed by the capping stage.
- op_ack  out  1  one-cycle pulse: operator load completed.
- op_err  out  1  one-cycle pulse: operator load rejected or aborted.
- sec_cnt  out  7  secondary-buffer count, 0..SEC_MAX.
- pri_cnt  out  5  main-buffer count, 0..PRI_MAX.
- ro  out  1  main buffer empty (`pri_cnt` == 0), combinational from the register.
- busy  out  1  FSM not in OCIOSO.
- estado  out  2  FSM state: 00 OCIOSO, 01 CARGA, 10 TRANSF (11 unused, recovers to OCIOSO).

## Operation
- Registers: state, `sec_cnt`, `pri_cnt`, `rem` (7-bit remaining counter), `op_pend`, `op_qtd_r`, `last_grant` (0 = operator, 1 = transfer), `op_ack`, `op_err`.
- Request capture:
  - `op_req` with `op_pend` = 0 and state != CARGA: set `op_pend`, latch `op_qtd_r`.
  - `op_req` otherwise: dropped, and `op_err` pulses.
- Transfer request `tr_req` = `enable` & (`pri_cnt` <= PRI_MIN) & (`sec_cnt` >= LOTE). It is a level, recomputed each cycle.
- OCIOSO with `enable` = 1:
  - Only one request pending: grant it.
  - Both pending: grant the one not equal to `last_grant`.
  - Every grant updates `last_grant`.
- Operator grant:
  - `op_qtd_r` == 0, or `sec_cnt` + `op_qtd_r` > SEC_MAX (compute as an 8-bit sum): reject. Pulse `op_err`, clear `op_pend`, stay in OCIOSO.
  - Otherwise: `rem` <= `op_qtd_r`, clear `op_pend`, go to CARGA.
- CARGA, each cycle: `sec_cnt`+1, `rem`-1. When `rem` reaches 1 (last step), go to OCIOSO and pulse `op_ack`.
- Transfer grant: `rem` <= LOTE, go to TRANSF.
- TRANSF, each cycle: `sec_cnt`-1, `pri_cnt`+1, `rem`-1. Return to OCIOSO after the last step. No ack output.
- Consumption (any state): `sel_ved` with `pri_cnt` > 0 decrements `pri_cnt`. With `pri_cnt` == 0 it is ignored.
- Same cycle as a TRANSF increment, the two cancel: `pri_cnt` is unchanged and `rem` still decrements.
- Overflow/underflow: the arithmetic never wraps. The capacity check and the grant conditions guarantee bounds, and the implementation additionally saturates at 0 and at the max values.
- `enable` falling while in CARGA or TRANSF:
  - FSM goes to OCIOSO at the next edge and `rem` clears.
  - Corks already moved stay moved.
  - CARGA abort pulses `op_err`; TRANSF abort is silent.
  - A pending `op_pend` is retained.

## Timing
- Reset (asynchronous): state OCIOSO, `sec_cnt`=0, `pri_cnt`=0, `rem`=0, `op_pend`=0, `last_grant`=1, `op_ack`=0, `op_err`=0, `busy`=0, `estado`=00, `ro`=1.
- Reset mid-operation discards everything, including any pending request. No pulse is emitted.
- Operator load of N from idle:
  - `op_req` sampled at edge k; grant at edge k+1.
  - `sec_cnt` increments at edges k+2 .. k+1+N.
  - `op_ack` is high in the cycle after edge k+1+N, concurrent with OCIOSO.
- Rejection: `op_err` is high in the cycle after edge k+1.
- Transfer: `tr_req` true at edge j (in OCIOSO) grants. Moves occur at edges j+1 .. j+LOTE, then OCIOSO.
- Back-to-back: a new grant can occur on the first OCIOSO cycle after completion. There is therefore one idle edge between operations.
- `op_ack` and `op_err` are registered, exactly one cycle wide, and never asserted together.

## Test plan
- Reset: assert `rst` mid-CARGA → all outputs immediately at their reset values; `ro`=1, `estado`=00.
- Operator load: `op_qtd`=30 from empty → `sec_cnt` reaches 30 after 30 cycles in CARGA; `op_ack` single pulse; `busy` low afterwards; then `tr_req` grants TRANSF → `sec_cnt`=15, `pri_cnt`=15.
- Capacity: `sec_cnt`=90, `op_qtd`=10 → `op_err` pulse, `sec_cnt` stays 90. `op_qtd`=9 → `sec_cnt`=99 with `op_ack`. `op_qtd`=0 → `op_err`.
- Arbitration: `pri_cnt`=3, `sec_cnt`=40, `op_req` (`op_qtd`=5) in the same cycle `tr_req` rises, `last_grant`=1 → CARGA first (`sec_cnt` 45), then TRANSF (`sec_cnt` 30, `pri_cnt` 18).
- Simultaneous consume: `sel_ved` pulsed on every TRANSF cycle starting at `pri_cnt`=5 → `pri_cnt` stays 5 throughout, `sec_cnt` drops by 15. `sel_ved` at `pri_cnt`=0 → stays 0, `ro`=1.
- Abort: drop `enable` after 4 CARGA steps of 20 → `sec_cnt`+4, `op_err` pulse, OCIOSO. Second `op_req` during CARGA → `op_err`, ignored.
